stack_spill_ctrl: RTL and testbench
===================================

# stack_spill_ctrl

Data-stack cache controller for the 16-bit stack CPU. Holds the top DEPTH data-stack entries on chip in a circular buffer and serves the push/pop requests produced by instruction decode. When the core pushes onto a full cache it spills the bottom entry to memory; when it pops an empty cache it fills from memory. In both cases it stalls the core through a single stall line and drives a req/ack memory handshake.

## Interface
- DEPTH, 8: on-chip entries; power of two, >= 2
- WIDTH, 16: data word width
- ADDR_W, 16: spill memory word-address width
- SPILL_BASE, 16'hFF00: memory address of the first spilled word; spill area grows upward
- MAX_SPILL, 256: spilled-word capacity
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_push  in  1  push request; core holds it while o_stall=1
- i_pop  in  1  pop request; core holds it while o_stall=1; i_push&i_pop = replace top
- i_push_data  in  WIDTH  value to push
- o_top  out  WIDTH  current top of stack; 0 when on-chip count is 0
- o_stall  out  1  combinational; request is not accepted this cycle
- o_count  out  clog2(DEPTH+1)  on-chip occupancy
- o_spilled  out  clog2(MAX_SPILL+1)  words currently held in memory
- o_err  out  1  sticky overflow/underflow flag, cleared only by reset
- o_mem_req, o_mem_we  out  1 each  memory request; write=1 spill, 0 fill
- o_mem_addr  out  ADDR_W  word address
- o_mem_wdata  out  WIDTH  spill data
- i_mem_ack  in  1  transaction complete; sampled only while o_mem_req=1
- i_mem_rdata  in  WIDTH  fill data, valid with i_mem_ack

## Operation
- State: circular buffer with bottom pointer b and count c; spill count s; FSM {IDLE, SPILL, FILL}.
- Accepted op = (i_push|i_pop) & ~o_stall & state==IDLE. It commits at the clock edge.
- Push with c<DEPTH: write at (b+c) mod DEPTH, c++.
- Pop with c>=1: c--.
- Push+pop with c>=1: overwrite top; c unchanged.
- Push with c==DEPTH and no pop, s<MAX_SPILL: o_stall=1 and go to SPILL. The controller registers addr=SPILL_BASE+s and wdata=entry[b]. On ack: b++, c--, s++, go to IDLE.
- Pop, or push+pop, with c==0 and s>0: o_stall=1 and go to FILL with addr=SPILL_BASE+s-1. On ack: b--, entry[b-1]=i_mem_rdata, c++, s--, go to IDLE.
- Overflow (push only, c==DEPTH, s==MAX_SPILL): the push is dropped, o_err set, no stall.
- Underflow (pop, c==0, s==0): the op is dropped, o_err set, no stall. o_top remains 0.
- o_stall = (state!=IDLE) | spill condition | fill condition.
- Address arithmetic wraps modulo 2^ADDR_W. Pointer arithmetic wraps modulo DEPTH.
- Reset values: c=0, b=0, s=0, state IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_err=0, o_top=0, o_stall=0 while push/pop are low.

## Timing
- Plain push/pop: zero stall cycles. o_top and o_count update the cycle after the accepting edge.
- Spill/fill sequence:
  - Cycle 0: request is seen, o_stall=1 combinationally.
  - Edge: state leaves IDLE.
  - Cycle 1 onward: o_mem_req=1 with address, we and wdata stable until ack.
  - Edge with i_mem_ack=1: o_mem_req deasserts, state returns to IDLE.
  - Next cycle: o_stall=0, and the held request is accepted at the end of that cycle.
  - Minimum is 3 edges from first presentation to commit, with ack in cycle 1.
- Only one memory transaction is outstanding at a time. i_mem_ack while o_mem_req=0 is ignored.
- The request inputs must stay stable while o_stall=1. A change mid-stall is the core's error; the controller still completes the memory transaction it started.
- Asynchronous reset mid-transaction: o_mem_req drops immediately and all state clears. The memory side must tolerate an abandoned request.

## Test plan
- Reset, then push 1..8 (DEPTH=8), one per cycle: no stall, o_count=8, o_top=8, no o_mem_req.
- Push 9 on full: one stall cycle, then req with we=1, addr=16'hFF00, wdata=1. Ack after 3 cycles. Then the push commits: o_top=9, o_count=8, o_spilled=1.
- From that state, pop 8 times (o_top goes 8..2, o_count 0), then pop again: fill with we=0, addr=16'hFF00. Return rdata=1 on ack. Pop commits: o_count=0, o_spilled=0, o_top=0.
- Push+pop on count 3 with data 16'hABCD: no stall, o_top=16'hABCD, o_count=3. Push+pop at c=0, s=1: fill first, then replace.
- Pop on an empty cache with s=0: no stall, o_err=1 and stays 1. Push with c=DEPTH, s=MAX_SPILL: dropped, no req.
- Assert i_rst_n low while o_mem_req=1 awaiting ack: o_mem_req=0 immediately. All counts are 0 after release, and a late ack is ignored.

Source files
------------

// File: rtl/stack_spill_ctrl.sv
// stack_spill_ctrl: on-chip data-stack cache for the 16-bit stack CPU.
// Spills the bottom entry on a full push, fills on an empty pop.
module stack_spill_ctrl #(
  parameter int unsigned       DEPTH      = 8,
  parameter int unsigned       WIDTH      = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SPILL_BASE = 16'hFF00,
  parameter int unsigned       MAX_SPILL  = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_push_data,
  output logic [WIDTH-1:0]               o_top,
  output logic                           o_stall,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic [$clog2(MAX_SPILL+1)-1:0] o_spilled,
  output logic                           o_err,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [WIDTH-1:0]               o_mem_wdata,
  input  logic                           i_mem_ack,
  input  logic [WIDTH-1:0]               i_mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(MAX_SPILL+1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [SW-1:0] S_MAX  = SW'(MAX_SPILL);

  typedef enum logic [1:0] {
    IDLE,
    SPILL,
    FILL
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  buf_q [DEPTH];
  logic [PW-1:0]     b_q, b_d;
  logic [CW-1:0]     c_q, c_d;
  logic [SW-1:0]     s_q, s_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;

  logic [PW-1:0]     top_idx;
  logic [PW-1:0]     push_idx;
  logic [PW-1:0]     wr_idx;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;

  logic idle;
  logic full;
  logic empty;
  logic spill_c;
  logic fill_c;
  logic acc;
  logic do_rep;
  logic do_push;
  logic do_pop;
  logic do_err;
  logic spill_ack;
  logic fill_ack;

  assign idle  = (state_q == IDLE);
  assign full  = (c_q == C_FULL);
  assign empty = (c_q == '0);

  assign spill_c = idle & i_push & ~i_pop
                 & full & (s_q != S_MAX);
  assign fill_c  = idle & i_pop & empty
                 & (s_q != '0);

  assign o_stall = ~idle | spill_c | fill_c;
  assign acc     = (i_push | i_pop) & ~o_stall;

  assign do_rep  = acc & i_push & i_pop & ~empty;
  assign do_push = acc & i_push & ~i_pop & ~full;
  assign do_pop  = acc & ~i_push & i_pop & ~empty;
  assign do_err  = acc & ((i_pop & empty)
                 | (i_push & ~i_pop & full));

  assign spill_ack = (state_q == SPILL) & i_mem_ack;
  assign fill_ack  = (state_q == FILL) & i_mem_ack;

  assign push_idx = b_q + PW'(c_q);
  assign top_idx  = push_idx - PW'(1);

  assign o_top       = empty ? '0 : buf_q[top_idx];
  assign o_count     = c_q;
  assign o_spilled   = s_q;
  assign o_err       = err_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

  // FSM next state; a request is outstanding whenever not idle
  always_comb begin
    state_d   = state_q;
    o_mem_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (spill_c) begin
          state_d = SPILL;
        end else if (fill_c) begin
          state_d = FILL;
        end
      end
      SPILL, FILL: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // capture the memory transaction as the FSM leaves idle
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (spill_c) begin
      we_d    = 1'b1;
      addr_d  = SPILL_BASE + ADDR_W'(s_q);
      wdata_d = buf_q[b_q];
    end else if (fill_c) begin
      we_d    = 1'b0;
      addr_d  = SPILL_BASE + ADDR_W'(s_q)
              - ADDR_W'(1);
    end
  end

  // pointer, counts, error flag and buffer write port
  always_comb begin
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = push_idx;
    wr_data = i_push_data;
    unique case (1'b1)
      spill_ack: begin
        b_d = b_q + PW'(1);
        c_d = c_q - CW'(1);
        s_d = s_q + SW'(1);
      end
      fill_ack: begin
        b_d     = b_q - PW'(1);
        c_d     = c_q + CW'(1);
        s_d     = s_q - SW'(1);
        wr_en   = 1'b1;
        wr_idx  = b_q - PW'(1);
        wr_data = i_mem_rdata;
      end
      do_rep: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      do_push: begin
        wr_en = 1'b1;
        c_d   = c_q + CW'(1);
      end
      do_pop: begin
        c_d = c_q - CW'(1);
      end
      do_err: begin
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // control and memory-interface state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // on-chip circular stack storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_q[PW'(i)] <= '0;
      end
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_stack_spill_ctrl.sv
// tb_stack_spill_ctrl: directed and random checks of the stack
// cache against a whole-stack queue model.
module tb_stack_spill_ctrl;

  localparam int D  = 8;
  localparam int MS = 256;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        push  = 1'b0;
  logic        pop   = 1'b0;
  logic [15:0] pdata = '0;
  logic [15:0] top;
  logic        stall;
  logic [3:0]  count;
  logic [8:0]  spilled;
  logic        err;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack   = 1'b0;
  logic [15:0] rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [15:0] stk[$];
  int c_m = 0;
  int s_m = 0;
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  stack_spill_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (push),
    .i_pop       (pop),
    .i_push_data (pdata),
    .o_top       (top),
    .o_stall     (stall),
    .o_count     (count),
    .o_spilled   (spilled),
    .o_err       (err),
    .o_mem_req   (req),
    .o_mem_we    (we),
    .o_mem_addr  (addr),
    .o_mem_wdata (wdata),
    .i_mem_ack   (ack),
    .i_mem_rdata (rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h",
             tag, got, exp);
    end
  endtask

  task automatic reset_model();
    stk.delete();
    c_m   = 0;
    s_m   = 0;
    err_m = 1'b0;
  endtask

  // Starts and ends just after a falling edge.
  task automatic do_op(input bit pu, input bit po,
                       input logic [15:0] d, input int dly);
    bit          sp;
    bit          fl;
    logic [15:0] a_e;
    logic [15:0] top_e;
    sp = pu && !po && c_m == D && s_m < MS;
    fl = po && c_m == 0 && s_m > 0;
    push  = pu;
    pop   = po;
    pdata = d;
    #1;
    chk("stall_in", 32'(stall), 32'(sp || fl));
    chk("req_idle", 32'(req), 32'(0));
    if (sp || fl) begin
      a_e = sp ? 16'hFF00 + 16'(s_m)
               : 16'hFF00 + 16'(s_m - 1);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k <= dly; k++) begin
        chk("req_held", 32'(req), 32'(1));
        chk("stall_held", 32'(stall), 32'(1));
        chk("mem_we", 32'(we), 32'(sp));
        chk("mem_addr", 32'(addr), 32'(a_e));
        if (sp) begin
          chk("mem_wdata", 32'(wdata), 32'(stk[s_m]));
        end
        if (k < dly) @(negedge clk);
      end
      ack   = 1'b1;
      rdata = fl ? stk[s_m-1] : 16'h0;
      @(posedge clk);
      @(negedge clk);
      ack = 1'b0;
      #1;
      chk("req_drop", 32'(req), 32'(0));
      chk("stall_clr", 32'(stall), 32'(0));
      if (sp) begin
        s_m++;
        c_m--;
      end else begin
        s_m--;
        c_m++;
      end
    end
    @(posedge clk);
    if (pu && po) begin
      if (c_m > 0) stk[stk.size()-1] = d;
      else err_m = 1'b1;
    end else if (pu) begin
      if (c_m < D) begin
        stk.push_back(d);
        c_m++;
      end else begin
        err_m = 1'b1;
      end
    end else if (po) begin
      if (c_m > 0) begin
        void'(stk.pop_back());
        c_m--;
      end else begin
        err_m = 1'b1;
      end
    end
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    top_e = (c_m > 0) ? stk[stk.size()-1] : 16'h0;
    chk("top", 32'(top), 32'(top_e));
    chk("count", 32'(count), 32'(c_m));
    chk("spilled", 32'(spilled), 32'(s_m));
    chk("err", 32'(err), 32'(err_m));
    chk("req_after", 32'(req), 32'(0));
  endtask

  initial begin
    int r;
    bit pu;
    bit po;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_top", 32'(top), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_req", 32'(req), 32'(0));
    chk("rst_we", 32'(we), 32'(0));
    chk("rst_addr", 32'(addr), 32'(0));
    chk("rst_wdata", 32'(wdata), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_spilled", 32'(spilled), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 1; i <= 8; i++) do_op(1, 0, 16'(i), 0);
    chk("full_top", 32'(top), 32'(8));
    chk("full_cnt", 32'(count), 32'(8));

    do_op(1, 0, 16'd9, 3);
    chk("spill_top", 32'(top), 32'(9));
    chk("spill_cnt", 32'(count), 32'(8));
    chk("spill_s", 32'(spilled), 32'(1));

    for (int i = 0; i < 8; i++) do_op(0, 1, 16'h0, 0);
    chk("drain_cnt", 32'(count), 32'(0));
    do_op(0, 1, 16'h0, 1);
    chk("fill_s", 32'(spilled), 32'(0));
    chk("fill_top", 32'(top), 32'(0));

    for (int i = 1; i <= 3; i++) do_op(1, 0, 16'(16 + i), 0);
    do_op(1, 1, 16'hABCD, 0);
    chk("rep_top", 32'(top), 32'hABCD);
    chk("rep_cnt", 32'(count), 32'(3));

    for (int i = 0; i < 6; i++) do_op(1, 0, 16'(32 + i), 0);
    for (int i = 0; i < 8; i++) do_op(0, 1, 16'h0, 0);
    chk("c0s1_s", 32'(spilled), 32'(1));
    do_op(1, 1, 16'h5A5A, 2);
    chk("repfill_top", 32'(top), 32'h5A5A);
    chk("repfill_cnt", 32'(count), 32'(1));

    do_op(0, 1, 16'h0, 0);
    do_op(0, 1, 16'h0, 0);
    chk("uflow_err", 32'(err), 32'(1));
    chk("uflow_top", 32'(top), 32'(0));
    do_op(1, 0, 16'h0077, 0);
    chk("err_sticky", 32'(err), 32'(1));

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      if (n < 300) begin
        pu = (r < 6) || (r >= 8);
        po = (r >= 6);
      end else begin
        pu = (r < 2) || (r >= 8);
        po = (r >= 2);
      end
      do_op(pu, po, 16'($urandom),
            int'($urandom_range(0, 2)));
    end

    for (int n = 0; n < 20 && c_m < D; n++) begin
      do_op(1, 0, 16'($urandom), 0);
    end
    push  = 1'b1;
    pdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    chk("mid_req", 32'(req), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req), 32'(0));
    chk("arst_cnt", 32'(count), 32'(0));
    chk("arst_s", 32'(spilled), 32'(0));
    chk("arst_top", 32'(top), 32'(0));
    push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("late_req", 32'(req), 32'(0));
    chk("late_stall", 32'(stall), 32'(0));
    chk("late_cnt", 32'(count), 32'(0));
    chk("late_s", 32'(spilled), 32'(0));
    chk("late_err", 32'(err), 32'(0));
    @(negedge clk);

    for (int n = 0; n < 400 && (s_m < MS || c_m < D); n++) begin
      do_op(1, 0, 16'($urandom), 0);
    end
    chk("ovf_s", 32'(spilled), 32'(MS));
    chk("ovf_pre_err", 32'(err), 32'(0));
    do_op(1, 0, 16'hDEAD, 0);
    chk("ovf_err", 32'(err), 32'(1));
    chk("ovf_cnt", 32'(count), 32'(8));
    chk("ovf_s2", 32'(spilled), 32'(MS));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
